// File: rtl/rx_frame_pkg.sv
// Shared state type and default sizing for the UART receive frame assembler.
package rx_frame_pkg;

  localparam int unsigned RX_DEPTH_DEFAULT = 64;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_DROP    = 2'd3
  } rx_state_e;

endpackage

// File: rtl/frame_buffer_ram.sv
// Simple dual-port DEPTH x 8 frame buffer: one write port, one registered read port.
module frame_buffer_ram
  import rx_frame_pkg::*;
#(
  parameter int unsigned DEPTH = RX_DEPTH_DEFAULT,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [7:0] mem_r [DEPTH];

  // Write port; contents are never reset so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // Registered read port; data only changes when a read is enabled.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data <= mem_r[rd_addr];
    end
  end

endmodule

// File: rtl/rx_frame_assembler.sv
// Collects UART bytes into a frame buffer until a receive timeout, then streams
// the frame out over a valid/ready interface or discards it when poisoned.
module rx_frame_assembler
  import rx_frame_pkg::*;
#(
  parameter int unsigned DEPTH        = RX_DEPTH_DEFAULT,
  parameter bit          CHECK_PARITY = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [7:0]               rx_data,
  input  logic                     rx_done,
  input  logic                     parity_err,
  input  logic                     timeout,
  output logic [7:0]               m_data,
  output logic                     m_valid,
  output logic                     m_last,
  input  logic                     m_ready,
  output logic [$clog2(DEPTH):0]   frame_len,
  output logic                     frame_err,
  output logic                     overrun,
  output logic                     busy
);

  localparam int unsigned    AW      = $clog2(DEPTH);
  localparam int unsigned    CW      = AW + 1;
  localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);

  rx_state_e       state_r, state_s;
  logic [CW-1:0]   count_r, count_s;
  logic            bad_r, bad_s;
  logic            wr_en_s;
  logic [AW-1:0]   wr_addr_s;
  logic            parity_bad_s;

  logic [CW-1:0]   rd_ptr_r, rd_addr_s;
  logic            rd_en_s;
  logic            fire_s;
  logic [7:0]      rd_data_s;
  logic            m_valid_r, m_last_r;
  logic [CW-1:0]   frame_len_r;

  logic            busy_s, frame_err_s, overrun_s;
  logic            busy_r, frame_err_r, overrun_r;

  assign parity_bad_s = rx_done && parity_err && CHECK_PARITY;
  assign fire_s       = m_valid_r && m_ready;
  assign rd_en_s      = (state_r == ST_DRAIN) && (!m_valid_r || (fire_s && !m_last_r));
  assign rd_addr_s    = fire_s ? (rd_ptr_r + CW'(1)) : rd_ptr_r;

  // Write side: buffer address, byte count and poison flag for the frame being collected.
  always_comb begin
    wr_en_s   = 1'b0;
    wr_addr_s = '0;
    count_s   = count_r;
    bad_s     = bad_r;
    case (state_r)
      ST_IDLE: begin
        if (rx_done) begin
          wr_en_s = 1'b1;
          count_s = CW'(1);
          bad_s   = parity_bad_s;
        end else begin
          count_s = count_r;
        end
      end
      ST_COLLECT: begin
        if (rx_done && (count_r != DEPTH_C)) begin
          wr_en_s   = 1'b1;
          wr_addr_s = count_r[AW-1:0];
          count_s   = count_r + CW'(1);
          bad_s     = bad_r || parity_bad_s;
        end else if (rx_done) begin
          bad_s = 1'b1;
        end else begin
          bad_s = bad_r;
        end
      end
      ST_DRAIN: begin
        if (fire_s && m_last_r) begin
          count_s = '0;
          bad_s   = 1'b0;
        end else begin
          count_s = count_r;
        end
      end
      ST_DROP: begin
        count_s = '0;
        bad_s   = 1'b0;
      end
      default: begin
        count_s = '0;
        bad_s   = 1'b0;
      end
    endcase
  end

  // Next state. A byte arriving together with timeout in IDLE forms a one-byte
  // frame; a lone timeout in IDLE is ignored.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (rx_done && timeout) begin
          state_s = bad_s ? ST_DROP : ST_DRAIN;
        end else if (rx_done) begin
          state_s = ST_COLLECT;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_COLLECT: begin
        if (timeout) begin
          state_s = bad_s ? ST_DROP : ST_DRAIN;
        end else begin
          state_s = ST_COLLECT;
        end
      end
      ST_DRAIN: begin
        if (fire_s && m_last_r) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      ST_DROP: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Status outputs, computed one cycle ahead and registered below.
  always_comb begin
    busy_s      = (state_s != ST_IDLE);
    frame_err_s = (state_s == ST_DROP);
    overrun_s   = (state_r == ST_DRAIN) && rx_done;
  end

  // State, collect-side counters and registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      count_r     <= '0;
      bad_r       <= 1'b0;
      busy_r      <= 1'b0;
      frame_err_r <= 1'b0;
      overrun_r   <= 1'b0;
    end else begin
      state_r     <= state_s;
      count_r     <= count_s;
      bad_r       <= bad_s;
      busy_r      <= busy_s;
      frame_err_r <= frame_err_s;
      overrun_r   <= overrun_s;
    end
  end

  // Drain side: the read is issued one cycle ahead so a held-high m_ready gets a byte per clock.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_r    <= '0;
      m_valid_r   <= 1'b0;
      m_last_r    <= 1'b0;
      frame_len_r <= '0;
    end else if ((state_r != ST_DRAIN) && (state_s == ST_DRAIN)) begin
      rd_ptr_r    <= '0;
      m_valid_r   <= 1'b0;
      m_last_r    <= 1'b0;
      frame_len_r <= count_s;
    end else if (fire_s && m_last_r) begin
      rd_ptr_r  <= '0;
      m_valid_r <= 1'b0;
      m_last_r  <= 1'b0;
    end else if (rd_en_s) begin
      rd_ptr_r  <= rd_addr_s;
      m_valid_r <= 1'b1;
      m_last_r  <= (rd_addr_s == (frame_len_r - CW'(1)));
    end
  end

  frame_buffer_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en_s),
    .wr_addr (wr_addr_s),
    .wr_data (rx_data),
    .rd_en   (rd_en_s),
    .rd_addr (rd_addr_s[AW-1:0]),
    .rd_data (rd_data_s)
  );

  assign m_data    = m_valid_r ? rd_data_s : 8'h00;
  assign m_valid   = m_valid_r;
  assign m_last    = m_last_r;
  assign frame_len = frame_len_r;
  assign frame_err = frame_err_r;
  assign overrun   = overrun_r;
  assign busy      = busy_r;

endmodule
